cnn_sync_rx: RTL and testbench
==============================

# cnn_sync_rx

Receive-side checker and position tracker for the CNN frame-timing protocol: consumes the vsync/hsync/data run strobes produced by the CNN controller and independently rebuilds row, column and data count for the downstream buffer-writer. It measures every blanking and data-run length against the programmed frame configuration and raises sticky error flags on any mismatch. It sits between the frame-timing source and the line/frame buffer logic, and gives the verification bench a self-checking sink.

## Interface
- W_SIZE, 12, width of width/height/row/col
- W_FRAME_SIZE, 2*W_SIZE+1, width of frame size / data count
- W_DELAY, 12, width of vsync/hsync delay fields
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- q_width  in  W_SIZE  expected data beats per line
- q_height  in  W_SIZE  expected lines per frame
- q_vsync_delay  in  W_DELAY  expected vsync run length (cycles)
- q_hsync_delay  in  W_DELAY  expected hsync run length (cycles)
- q_frame_size  in  W_FRAME_SIZE  expected beats per frame
- i_vsync_run  in  1  vsync blanking strobe
- i_hsync_run  in  1  hsync blanking strobe
- i_data_run  in  1  data beat strobe
- i_err_clr  in  1  clears sticky error flags
- o_valid  out  1  registered copy of accepted data beat
- o_row  out  W_SIZE  row of beat flagged by o_valid
- o_col  out  W_SIZE  column of beat flagged by o_valid
- o_data_count  out  W_FRAME_SIZE  frame-linear index of that beat
- o_line_done  out  1  one-cycle pulse after last beat of a line
- o_frame_done  out  1  one-cycle pulse at frame end
- o_frame_ok  out  1  pulse with o_frame_done when frame error-free
- o_busy  out  1  high in any state other than IDLE
- o_err  out  5  sticky errors: [0] vsync len, [1] hsync len, [2] line width, [3] height/frame size, [4] order/overlap

## Operation
- States: IDLE, VSYNC, WAIT_H, HSYNC, DATA, DONE.
- IDLE: i_vsync_run=1 -> VSYNC, vsync counter=1. hsync/data strobes in IDLE ignored.
- VSYNC: count while high; on fall compare to q_vsync_delay (mismatch -> err[0]); -> WAIT_H.
- WAIT_H: idle cycles allowed; i_hsync_run=1 -> HSYNC (counter=1); i_data_run=1 -> err[4], abort; i_vsync_run=1 -> err[3] (short frame), abort.
- HSYNC: count; on fall compare to q_hsync_delay (err[1]); data_run rising in same cycle as hsync falls or any later cycle -> DATA. Gap cycles allowed.
- DATA: each beat: o_valid, col++, data_count++. On fall: col != q_width -> err[2]; o_line_done; row++; row==q_height -> DONE else WAIT_H.
- DONE (one cycle): o_frame_done=1; data_count != q_frame_size -> err[3]; o_frame_ok=1 iff no error set during this frame; -> IDLE.
- Overlap: two or more run inputs high in one cycle -> err[4], abort.
- Abort: no o_frame_done; state -> IDLE; row/col/data_count reset to 0. A vsync_run high on the abort cycle is not taken; next rising edge starts a frame.
- Counters saturate at all-ones; no wrap.
- i_err_clr clears o_err next cycle; same-cycle new error wins (flag stays set).

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- o_valid/o_row/o_col/o_data_count: 1-cycle latency after i_data_run; first beat of frame reports row 0, col 0, count 0.
- o_line_done: cycle after the first i_data_run=0 following a data run.
- o_frame_done/o_frame_ok: cycle after o_line_done of last line.
- Length errors set the cycle after the falling edge is seen.
- rst mid-frame: immediate return to IDLE, errors cleared, no pulses.

## Structure
- Package cnn_sync_pkg: state enum, error bit index constants (ERR_VSYNC..ERR_ORDER), error vector width 5.
- Sub-module cnn_run_len: edge detect + saturating run-length counter with rise/fall pulses and length output, instantiated for vsync and hsync.

## Test plan
- Width 4, height 3, vsync 5, hsync 2, frame 12, clean stream -> 12 o_valid beats, counts 0..11, three o_line_done, o_frame_done+o_frame_ok, o_err=0.
- Same config, vsync run 6 cycles -> err[0]=1, frame completes, o_frame_ok=0.
- Line 1 with 3 beats -> err[2], row advances, DONE sets err[3] (count 11), o_frame_ok=0.
- data_run directly after vsync (no hsync) -> err[4], abort, no o_frame_done; next clean frame -> o_frame_ok=1, o_err still 0x10 until i_err_clr.
- hsync_run and data_run high together -> err[4], abort to IDLE, o_busy=0 next cycle.
- rst asserted during row 1, col 2 -> all outputs 0 asynchronously; following clean frame reports row 0, col 0 first.

Source files
------------

// File: rtl/cnn_sync_pkg.sv
// Shared types and constants for the CNN frame-timing receive checker.
// Holds the FSM state encoding and the bit positions of the sticky error vector.
package cnn_sync_pkg;

    localparam int unsigned ERR_W     = 5;
    localparam int unsigned ERR_VSYNC = 0;
    localparam int unsigned ERR_HSYNC = 1;
    localparam int unsigned ERR_WIDTH = 2;
    localparam int unsigned ERR_FRAME = 3;
    localparam int unsigned ERR_ORDER = 4;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StWaitH,
        StHsync,
        StData,
        StDone
    } state_e;

endpackage

// File: rtl/cnn_run_len.sv
// Edge detector with a saturating run-length counter for one strobe.
// The length stays valid on the fall cycle and holds until the next rise.
module cnn_run_len
    import cnn_sync_pkg::*;
#(
    parameter int unsigned Width = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic [Width-1:0] len_o
);

    logic             run_q;
    logic [Width-1:0] len_q, len_d;

    assign rise_o = run_i & ~run_q;
    assign fall_o = ~run_i & run_q;
    assign len_o  = len_q;

    always_comb begin
        len_d = len_q;
        if (rise_o) begin
            len_d = {{(Width-1){1'b0}}, 1'b1};
        end else if (run_i && (len_q != {Width{1'b1}})) begin
            len_d = len_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q <= 1'b0;
            len_q <= '0;
        end else begin
            run_q <= run_i;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/cnn_sync_rx.sv
// Receive-side checker for CNN vsync/hsync/data run strobes: rebuilds row, column
// and frame-linear beat index, and flags timing mismatches in sticky error bits.
module cnn_sync_rx
    import cnn_sync_pkg::*;
#(
    parameter int unsigned W_SIZE       = 12,
    parameter int unsigned W_FRAME_SIZE = 2 * W_SIZE + 1,
    parameter int unsigned W_DELAY      = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W_SIZE-1:0]       q_width,
    input  logic [W_SIZE-1:0]       q_height,
    input  logic [W_DELAY-1:0]      q_vsync_delay,
    input  logic [W_DELAY-1:0]      q_hsync_delay,
    input  logic [W_FRAME_SIZE-1:0] q_frame_size,
    input  logic                    i_vsync_run,
    input  logic                    i_hsync_run,
    input  logic                    i_data_run,
    input  logic                    i_err_clr,
    output logic                    o_valid,
    output logic [W_SIZE-1:0]       o_row,
    output logic [W_SIZE-1:0]       o_col,
    output logic [W_FRAME_SIZE-1:0] o_data_count,
    output logic                    o_line_done,
    output logic                    o_frame_done,
    output logic                    o_frame_ok,
    output logic                    o_busy,
    output logic [ERR_W-1:0]        o_err
);

    state_e                  state_q;
    logic [W_SIZE-1:0]       row_q, col_q, row_inc, col_inc;
    logic [W_FRAME_SIZE-1:0] cnt_q, cnt_inc;
    logic [W_SIZE-1:0]       out_row_q, out_col_q;
    logic [W_FRAME_SIZE-1:0] out_cnt_q;
    logic                    valid_q, line_done_q, frame_done_q, frame_ok_q;
    logic [ERR_W-1:0]        err_q, err_set;
    logic                    frame_err_q;
    logic                    abort, beat, overlap;

    logic               vs_rise, vs_fall, hs_rise, hs_fall;
    logic [W_DELAY-1:0] vs_len, hs_len;

    cnn_run_len #(.Width(W_DELAY)) u_vsync_len (
        .clk_i  (clk),
        .rst_i  (rst),
        .run_i  (i_vsync_run),
        .rise_o (vs_rise),
        .fall_o (vs_fall),
        .len_o  (vs_len)
    );

    cnn_run_len #(.Width(W_DELAY)) u_hsync_len (
        .clk_i  (clk),
        .rst_i  (rst),
        .run_i  (i_hsync_run),
        .rise_o (hs_rise),
        .fall_o (hs_fall),
        .len_o  (hs_len)
    );

    assign overlap = (i_vsync_run & i_hsync_run) | (i_vsync_run & i_data_run)
                   | (i_hsync_run & i_data_run);
    assign row_inc = (row_q == {W_SIZE{1'b1}}) ? row_q : row_q + 1'b1;
    assign col_inc = (col_q == {W_SIZE{1'b1}}) ? col_q : col_q + 1'b1;
    assign cnt_inc = (cnt_q == {W_FRAME_SIZE{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        err_set = '0;
        abort   = 1'b0;
        beat    = 1'b0;
        case (state_q)
            StVsync: begin
                if (vs_fall) begin
                    if (vs_len != q_vsync_delay) err_set[ERR_VSYNC] = 1'b1;
                    if (i_data_run) begin
                        err_set[ERR_ORDER] = 1'b1;
                        abort              = 1'b1;
                    end
                end
            end
            StWaitH: begin
                if (i_data_run) begin
                    err_set[ERR_ORDER] = 1'b1;
                    abort              = 1'b1;
                end else if (i_vsync_run) begin
                    err_set[ERR_FRAME] = 1'b1;
                    abort              = 1'b1;
                end
            end
            StHsync: begin
                if (hs_fall && (hs_len != q_hsync_delay)) err_set[ERR_HSYNC] = 1'b1;
                // A second hsync before any data means the line is malformed.
                if (i_vsync_run || hs_rise) begin
                    err_set[ERR_ORDER] = 1'b1;
                    abort              = 1'b1;
                end else if (i_data_run) begin
                    beat = 1'b1;
                end
            end
            StData: begin
                if (i_vsync_run) begin
                    err_set[ERR_ORDER] = 1'b1;
                    abort              = 1'b1;
                end else if (i_data_run) begin
                    beat = 1'b1;
                end else if (col_q != q_width) begin
                    err_set[ERR_WIDTH] = 1'b1;
                end
            end
            StDone: begin
                if (cnt_q != q_frame_size) err_set[ERR_FRAME] = 1'b1;
            end
            default: ;
        endcase
        if ((state_q != StIdle) && overlap) begin
            err_set[ERR_ORDER] = 1'b1;
            abort              = 1'b1;
            beat               = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            cnt_q        <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_cnt_q    <= '0;
            valid_q      <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_q        <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            err_q        <= (i_err_clr ? '0 : err_q) | err_set;
            frame_err_q  <= frame_err_q | (|err_set);
            valid_q      <= beat;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            if (beat) begin
                out_row_q <= row_q;
                out_col_q <= col_q;
                out_cnt_q <= cnt_q;
                col_q     <= col_inc;
                cnt_q     <= cnt_inc;
            end
            if (abort) begin
                state_q <= StIdle;
                row_q   <= '0;
                col_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        // Only a fresh rising edge starts a frame, never a held-over vsync.
                        if (vs_rise) begin
                            state_q     <= StVsync;
                            row_q       <= '0;
                            col_q       <= '0;
                            cnt_q       <= '0;
                            frame_err_q <= 1'b0;
                        end
                    end
                    StVsync: begin
                        if (vs_fall) state_q <= i_hsync_run ? StHsync : StWaitH;
                    end
                    StWaitH: begin
                        if (i_hsync_run) state_q <= StHsync;
                    end
                    StHsync: begin
                        if (beat) state_q <= StData;
                    end
                    StData: begin
                        if (!i_data_run) begin
                            line_done_q <= 1'b1;
                            col_q       <= '0;
                            row_q       <= row_inc;
                            if (row_inc == q_height) begin
                                state_q <= StDone;
                            end else begin
                                state_q <= i_hsync_run ? StHsync : StWaitH;
                            end
                        end
                    end
                    StDone: begin
                        frame_done_q <= 1'b1;
                        frame_ok_q   <= ~frame_err_q & ~(|err_set);
                        state_q      <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_valid      = valid_q;
    assign o_row        = out_row_q;
    assign o_col        = out_col_q;
    assign o_data_count = out_cnt_q;
    assign o_line_done  = line_done_q;
    assign o_frame_done = frame_done_q;
    assign o_frame_ok   = frame_ok_q;
    assign o_busy       = (state_q != StIdle);
    assign o_err        = err_q;

endmodule

// File: tb/tb_cnn_sync_rx.sv
// Directed self-checking bench for cnn_sync_rx: 4x3 frames with vsync 5 / hsync 2,
// clean and faulty strobe sequences, error clearing and mid-frame reset.
module tb_cnn_sync_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] q_width = 12'd4;
    logic [11:0] q_height = 12'd3;
    logic [11:0] q_vsync_delay = 12'd5;
    logic [11:0] q_hsync_delay = 12'd2;
    logic [24:0] q_frame_size = 25'd12;
    logic        vs = 1'b0, hs = 1'b0, dr = 1'b0, err_clr = 1'b0;

    logic        o_valid, o_line_done, o_frame_done, o_frame_ok, o_busy;
    logic [11:0] o_row, o_col;
    logic [24:0] o_data_count;
    logic [4:0]  o_err;

    int checks = 0;
    int failures = 0;

    int n_line = 0, n_frame = 0, n_ok = 0;
    int beat_row[$], beat_col[$], beat_cnt[$];

    cnn_sync_rx dut (
        .clk           (clk),
        .rst           (rst),
        .q_width       (q_width),
        .q_height      (q_height),
        .q_vsync_delay (q_vsync_delay),
        .q_hsync_delay (q_hsync_delay),
        .q_frame_size  (q_frame_size),
        .i_vsync_run   (vs),
        .i_hsync_run   (hs),
        .i_data_run    (dr),
        .i_err_clr     (err_clr),
        .o_valid       (o_valid),
        .o_row         (o_row),
        .o_col         (o_col),
        .o_data_count  (o_data_count),
        .o_line_done   (o_line_done),
        .o_frame_done  (o_frame_done),
        .o_frame_ok    (o_frame_ok),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    // Event log sampled mid-cycle; tests compare deltas against it.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) begin
                beat_row.push_back(int'(o_row));
                beat_col.push_back(int'(o_col));
                beat_cnt.push_back(int'(o_data_count));
            end
            if (o_line_done) n_line++;
            if (o_frame_done) n_frame++;
            if (o_frame_ok) n_ok++;
        end
    end

    task automatic drive(input logic v, input logic h, input logic d);
        vs = v;
        hs = h;
        dr = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int vlen, input int hlen, input int w0, input int w1,
                              input int w2);
        int w;
        repeat (vlen) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            w = (r == 0) ? w0 : ((r == 1) ? w1 : w2);
            repeat (hlen) drive(1'b0, 1'b1, 1'b0);
            repeat (w) drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0);
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_err(input string name);
        err_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        checks++;
        if (o_err !== 5'h00) begin
            failures++;
            $display("FAIL %s: o_err got %h want 00", name, o_err);
        end
    endtask

    task automatic test_reset();
        logic [58:0] all_out;
        repeat (2) @(posedge clk);
        #1;
        all_out = {o_valid, o_row, o_col, o_data_count, o_line_done, o_frame_done,
                   o_frame_ok, o_busy, o_err};
        checks++;
        if (all_out !== 59'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignores_strobes: busy=%b valid=%b want 0 0", o_busy, o_valid);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clean();
        int b0 = beat_row.size();
        int l0 = n_line, f0 = n_frame, k0 = n_ok;
        send_frame(5, 2, 4, 4, 4);
        checks++;
        if (beat_row.size() - b0 !== 12) begin
            failures++;
            $display("FAIL clean_beats: got %0d want 12", beat_row.size() - b0);
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (beat_row[b0+i] !== i / 4 || beat_col[b0+i] !== i % 4
                    || beat_cnt[b0+i] !== i) begin
                    failures++;
                    $display("FAIL clean_beat%0d: got r%0d c%0d n%0d want r%0d c%0d n%0d", i,
                             beat_row[b0+i], beat_col[b0+i], beat_cnt[b0+i], i / 4, i % 4, i);
                end
            end
        end
        checks++;
        if (n_line - l0 !== 3 || n_frame - f0 !== 1 || n_ok - k0 !== 1) begin
            failures++;
            $display("FAIL clean_pulses: line=%0d frame=%0d ok=%0d want 3 1 1",
                     n_line - l0, n_frame - f0, n_ok - k0);
        end
        checks++;
        if (o_err !== 5'h00 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL clean_err: err=%h busy=%b want 00 0", o_err, o_busy);
        end
    endtask

    task automatic test_vsync_len();
        int b0 = beat_row.size();
        int f0 = n_frame, k0 = n_ok;
        send_frame(6, 2, 4, 4, 4);
        checks++;
        if (beat_row.size() - b0 !== 12 || n_frame - f0 !== 1 || n_ok - k0 !== 0) begin
            failures++;
            $display("FAIL vsync_len_frame: beats=%0d frame=%0d ok=%0d want 12 1 0",
                     beat_row.size() - b0, n_frame - f0, n_ok - k0);
        end
        checks++;
        if (o_err !== 5'h01) begin
            failures++;
            $display("FAIL vsync_len_err: got %h want 01", o_err);
        end
        clear_err("vsync_len_clr");
    endtask

    task automatic test_short_line();
        int b0 = beat_row.size();
        int l0 = n_line, f0 = n_frame, k0 = n_ok;
        send_frame(5, 2, 4, 3, 4);
        checks++;
        if (beat_row.size() - b0 !== 11) begin
            failures++;
            $display("FAIL short_beats: got %0d want 11", beat_row.size() - b0);
        end else begin
            checks++;
            if (beat_row[b0+7] !== 2 || beat_col[b0+7] !== 0 || beat_cnt[b0+7] !== 7) begin
                failures++;
                $display("FAIL short_row2_start: got r%0d c%0d n%0d want r2 c0 n7",
                         beat_row[b0+7], beat_col[b0+7], beat_cnt[b0+7]);
            end
        end
        checks++;
        if (n_line - l0 !== 3 || n_frame - f0 !== 1 || n_ok - k0 !== 0) begin
            failures++;
            $display("FAIL short_pulses: line=%0d frame=%0d ok=%0d want 3 1 0",
                     n_line - l0, n_frame - f0, n_ok - k0);
        end
        checks++;
        if (o_err !== 5'h0c) begin
            failures++;
            $display("FAIL short_err: got %h want 0c", o_err);
        end
        clear_err("short_clr");
    endtask

    task automatic test_order();
        int f0 = n_frame, k0;
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (o_busy !== 1'b0 || o_err !== 5'h10) begin
            failures++;
            $display("FAIL order_abort: busy=%b err=%h want 0 10", o_busy, o_err);
        end
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (n_frame - f0 !== 0) begin
            failures++;
            $display("FAIL order_no_frame: got %0d frame_done want 0", n_frame - f0);
        end
        f0 = n_frame;
        k0 = n_ok;
        send_frame(5, 2, 4, 4, 4);
        checks++;
        if (n_frame - f0 !== 1 || n_ok - k0 !== 1) begin
            failures++;
            $display("FAIL order_next_frame: frame=%0d ok=%0d want 1 1", n_frame - f0, n_ok - k0);
        end
        checks++;
        if (o_err !== 5'h10) begin
            failures++;
            $display("FAIL order_sticky: got %h want 10", o_err);
        end
        clear_err("order_clr");
    endtask

    task automatic test_overlap();
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL overlap_busy_before: got %b want 1", o_busy);
        end
        // Clear request coincides with a new error; the new error must survive.
        err_clr = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        err_clr = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_err !== 5'h10) begin
            failures++;
            $display("FAIL overlap_abort: busy=%b err=%h want 0 10", o_busy, o_err);
        end
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        clear_err("overlap_clr");
    endtask

    task automatic test_reset_mid();
        logic [58:0] all_out;
        int          b0, k0;
        repeat (6) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_row !== 12'd1 || o_col !== 12'd1 || o_data_count !== 25'd5
            || o_err !== 5'h01) begin
            failures++;
            $display("FAIL mid_before_rst: v=%b r%0d c%0d n%0d err=%h want 1 r1 c1 n5 01",
                     o_valid, o_row, o_col, o_data_count, o_err);
        end
        vs = 1'b0;
        hs = 1'b0;
        dr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        all_out = {o_valid, o_row, o_col, o_data_count, o_line_done, o_frame_done,
                   o_frame_ok, o_busy, o_err};
        checks++;
        if (all_out !== 59'd0) begin
            failures++;
            $display("FAIL mid_rst_async: got %h want 0", all_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        b0 = beat_row.size();
        k0 = n_ok;
        send_frame(5, 2, 4, 4, 4);
        checks++;
        if (beat_row.size() - b0 !== 12) begin
            failures++;
            $display("FAIL mid_after_beats: got %0d want 12", beat_row.size() - b0);
        end else begin
            checks++;
            if (beat_row[b0] !== 0 || beat_col[b0] !== 0 || beat_cnt[b0] !== 0) begin
                failures++;
                $display("FAIL mid_after_first: got r%0d c%0d n%0d want r0 c0 n0",
                         beat_row[b0], beat_col[b0], beat_cnt[b0]);
            end
        end
        checks++;
        if (n_ok - k0 !== 1 || o_err !== 5'h00) begin
            failures++;
            $display("FAIL mid_after_ok: ok=%0d err=%h want 1 00", n_ok - k0, o_err);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_vsync_len();
        test_short_line();
        test_order();
        test_overlap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
